// File: rtl/simmem_pkg.sv
// simmem_pkg
// Shared types and defaults for the simulated-memory response path.
// - Default* constants give the parameter defaults of simmem_delay_tracker.
// - slot_t is the record kept for each tracked entry at the default widths.
//   The tracker declares an equivalent record sized by its own parameters.
package simmem_pkg;

  localparam int unsigned DefaultIdWidth    = 6;
  localparam int unsigned DefaultDelayWidth = 8;
  localparam int unsigned DefaultNumSlots   = 8;
  localparam int unsigned DefaultFixedDelay = 10;

  typedef struct packed {
    logic                         valid;
    logic [DefaultIdWidth-1:0]    id;
    logic [DefaultDelayWidth-1:0] counter;
  } slot_t;

endpackage

// File: rtl/simmem_age_matrix.sv
// simmem_age_matrix
// Tracks the arrival order of NumSlots slots and picks the oldest requester.
// Ports:
//   clk_i    in  clock
//   rst_ni   in  asynchronous active-low reset
//   set_i    in  one-hot, slot being allocated this cycle (becomes youngest)
//   clear_i  in  one-hot, slot being freed this cycle
//   req_i    in  mask of slots competing for selection
//   oldest_o out one-hot of the oldest requesting slot (zero when no request)
module simmem_age_matrix import simmem_pkg::*; #(
  parameter int unsigned NumSlots = DefaultNumSlots
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumSlots-1:0] set_i,
  input  logic [NumSlots-1:0] clear_i,
  input  logic [NumSlots-1:0] req_i,
  output logic [NumSlots-1:0] oldest_o
);

  // older_q[i][j] = 1 means slot i arrived before slot j.
  logic [NumSlots-1:0] older_q [NumSlots];
  logic [NumSlots-1:0] occupied_q;
  logic [NumSlots-1:0] blocked;

  // A newly allocated slot is younger than every slot that stays occupied,
  // so its row is cleared and its column copies the surviving occupancy.
  // Freed slots drop out of both their row and column so stale order
  // information can never block a later requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      occupied_q <= (occupied_q & ~clear_i) | set_i;
      for (int i = 0; i < NumSlots; i++) begin
        for (int j = 0; j < NumSlots; j++) begin
          if (set_i[i]) begin
            older_q[i][j] <= 1'b0;
          end else if (set_i[j]) begin
            older_q[i][j] <= occupied_q[i] && !clear_i[i];
          end else if (clear_i[i] || clear_i[j]) begin
            older_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    oldest_o = '0;
    blocked  = '0;
    for (int j = 0; j < NumSlots; j++) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (req_i[i] && older_q[i][j]) begin
          blocked[j] = 1'b1;
        end
      end
      oldest_o[j] = req_i[j] && !blocked[j];
    end
  end

endmodule

// File: rtl/simmem_delay_tracker.sv
// simmem_delay_tracker
// Holds up to NumSlots in-flight identifiers, each with its own down-counting
// delay, and releases them oldest-first once expired. A presented output is
// held stable until the downstream accepts it.
// Ports:
//   clk_i        in  clock
//   rst_ni       in  asynchronous active-low reset
//   in_id_i      in  identifier to delay
//   in_delay_i   in  requested delay (used only when UseInputDelay=1)
//   in_valid_i   in  request valid
//   in_ready_o   out a free slot exists
//   out_id_o     out identifier whose delay has elapsed
//   out_valid_o  out out_id_o is valid
//   out_ready_i  in  downstream accepts out_id_o
//   occupancy_o  out number of occupied slots
module simmem_delay_tracker import simmem_pkg::*; #(
  parameter int unsigned IdWidth       = DefaultIdWidth,
  parameter int unsigned DelayWidth    = DefaultDelayWidth,
  parameter int unsigned NumSlots      = DefaultNumSlots,
  parameter int unsigned FixedDelay    = DefaultFixedDelay,
  parameter bit          UseInputDelay = 1'b0,
  localparam int unsigned OccWidth     = $clog2(NumSlots + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IdWidth-1:0]    in_id_i,
  input  logic [DelayWidth-1:0] in_delay_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [IdWidth-1:0]    out_id_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OccWidth-1:0]   occupancy_o
);

  typedef struct packed {
    logic                  valid;
    logic [IdWidth-1:0]    id;
    logic [DelayWidth-1:0] counter;
  } tracked_slot_t;

  tracked_slot_t slots_q [NumSlots];

  logic [NumSlots-1:0]   free_vec;
  logic [NumSlots-1:0]   expired_vec;
  logic [NumSlots-1:0]   alloc_oh;
  logic [NumSlots-1:0]   alloc_set;
  logic [NumSlots-1:0]   oldest_oh;
  logic [NumSlots-1:0]   sel_oh;
  logic [NumSlots-1:0]   release_oh;
  logic [NumSlots-1:0]   lock_oh_q;
  logic                  lock_q;
  logic                  in_fire;
  logic                  out_fire;
  logic [DelayWidth-1:0] eff_delay;
  logic [DelayWidth-1:0] load_value;
  logic [OccWidth-1:0]   occ_q;

  // Per-slot status: free slots feed the allocator, expired slots compete
  // for the output.
  always_comb begin
    free_vec    = '0;
    expired_vec = '0;
    for (int i = 0; i < NumSlots; i++) begin
      free_vec[i]    = !slots_q[i].valid;
      expired_vec[i] = slots_q[i].valid && (slots_q[i].counter == '0);
    end
  end

  // Lowest-index free slot; scanning downwards lets the lowest index win.
  always_comb begin
    alloc_oh = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  // A delay of D makes the entry eligible D cycles after acceptance, so the
  // counter starts at D-1; zero is treated as one.
  assign eff_delay  = UseInputDelay ? in_delay_i : DelayWidth'(FixedDelay);
  assign load_value = (eff_delay == '0) ? '0 : eff_delay - DelayWidth'(1);

  assign in_ready_o = |free_vec;
  assign in_fire    = in_valid_i && in_ready_o;
  assign alloc_set  = in_fire ? alloc_oh : '0;

  // While locked, the slot captured at the stall stays presented even if an
  // older slot expires in the meantime.
  assign sel_oh      = lock_q ? lock_oh_q : oldest_oh;
  assign out_valid_o = lock_q || (|expired_vec);
  assign out_fire    = out_valid_o && out_ready_i;
  assign release_oh  = out_fire ? sel_oh : '0;

  always_comb begin
    out_id_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (out_valid_o && sel_oh[i]) begin
        out_id_o = slots_q[i].id;
      end
    end
  end

  simmem_age_matrix #(
    .NumSlots (NumSlots)
  ) u_age_matrix (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_i    (alloc_set),
    .clear_i  (release_oh),
    .req_i    (expired_vec),
    .oldest_o (oldest_oh)
  );

  // Slot storage: load on allocation, free on release, otherwise count down
  // and saturate at zero. Allocation and release never target the same slot
  // because one needs it free and the other needs it occupied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (alloc_set[i]) begin
          slots_q[i].valid   <= 1'b1;
          slots_q[i].id      <= in_id_i;
          slots_q[i].counter <= load_value;
        end else if (release_oh[i]) begin
          slots_q[i].valid   <= 1'b0;
        end else if (slots_q[i].valid && (slots_q[i].counter != '0)) begin
          slots_q[i].counter <= slots_q[i].counter - DelayWidth'(1);
        end
      end
    end
  end

  // Lock captures the presented slot when the downstream stalls and clears
  // on the handshake, so a fresh selection happens the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
    end else if (out_valid_o && !out_ready_i) begin
      lock_q    <= 1'b1;
      lock_oh_q <= sel_oh;
    end else if (out_fire) begin
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
    end
  end

  // Occupancy follows accepts and releases; both together cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + OccWidth'(1);
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - OccWidth'(1);
    end
  end

  assign occupancy_o = occ_q;

endmodule
